// File: rtl/spi_byte_port.sv
// rtl/spi_byte_port.sv - SPI mode-0 slave byte port clocked from clock_50
//
// Purpose: full-duplex, byte-oriented SPI slave. sclk, mosi and ss are
// oversampled by clock_50 through 3-flop synchronisers. Received bytes are
// reported with a one-cycle strobe. Transmit bytes are taken from byte_send
// at frame start and at each byte boundary.
//
// Ports:
//   clock_50           in   system clock, rising edge
//   reset              in   asynchronous, active-low reset
//   sclk, mosi, ss     in   SPI host signals (ss active-low)
//   miso               out  SPI data to host, high-Z outside a frame
//   byte_send          in   next byte to transmit
//   byte_received      out  one-cycle strobe, byte_data_received is new
//   byte_data_received out  last complete received byte
//   frame_start        out  one-cycle strobe on ss assertion
//   frame_end          out  one-cycle strobe on ss deassertion
//   byte_index         out  bytes completed in the current frame (mod 256)
`timescale 1ns/1ps
module spi_byte_port (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss,
  output logic       miso,
  input  logic [7:0] byte_send,
  output logic       byte_received,
  output logic [7:0] byte_data_received,
  output logic       frame_start,
  output logic       frame_end,
  output logic [7:0] byte_index
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] mosi_sync_q, mosi_sync_d;
  logic [2:0] ss_sync_q, ss_sync_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] byte_index_q, byte_index_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_received_q, byte_received_d;
  logic       frame_start_q, frame_start_d;
  logic       frame_end_q, frame_end_d;
  logic       byte_done_q, byte_done_d;
  logic [1:0] init_q, init_d;
  logic       armed_q, armed_d;

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_bit;

  // Index 0 is the newest sample; edges come from the two oldest flops.
  assign sclk_rise = (sclk_sync_q[2:1] == 2'b01);
  assign sclk_fall = (sclk_sync_q[2:1] == 2'b10);
  assign ss_rise   = (ss_sync_q[2:1] == 2'b01);
  assign ss_fall   = (ss_sync_q[2:1] == 2'b10);
  assign mosi_bit  = mosi_sync_q[2];

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      sclk_sync_q     <= 3'b000;
      mosi_sync_q     <= 3'b000;
      ss_sync_q       <= 3'b111;
      bit_cnt_q       <= 3'd0;
      rx_shift_q      <= 8'h00;
      tx_shift_q      <= 8'h00;
      byte_index_q    <= 8'h00;
      byte_data_q     <= 8'h00;
      byte_received_q <= 1'b0;
      frame_start_q   <= 1'b0;
      frame_end_q     <= 1'b0;
      byte_done_q     <= 1'b0;
      init_q          <= 2'd0;
      armed_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      sclk_sync_q     <= sclk_sync_d;
      mosi_sync_q     <= mosi_sync_d;
      ss_sync_q       <= ss_sync_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_shift_q      <= rx_shift_d;
      tx_shift_q      <= tx_shift_d;
      byte_index_q    <= byte_index_d;
      byte_data_q     <= byte_data_d;
      byte_received_q <= byte_received_d;
      frame_start_q   <= frame_start_d;
      frame_end_q     <= frame_end_d;
      byte_done_q     <= byte_done_d;
      init_q          <= init_d;
      armed_q         <= armed_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    sclk_sync_d     = {sclk_sync_q[1:0], sclk};
    mosi_sync_d     = {mosi_sync_q[1:0], mosi};
    ss_sync_d       = {ss_sync_q[1:0], ss};
    bit_cnt_d       = bit_cnt_q;
    rx_shift_d      = rx_shift_q;
    tx_shift_d      = tx_shift_q;
    byte_index_d    = byte_index_q;
    byte_data_d     = byte_data_q;
    byte_received_d = 1'b0;
    frame_start_d   = 1'b0;
    frame_end_d     = 1'b0;
    byte_done_d     = byte_done_q;
    init_d          = (init_q == 2'd3) ? init_q : init_q + 2'd1;
    // The ss chain comes out of reset preset high. A frame may only start
    // once the chain has flushed and genuinely shown ss high, so a host
    // holding ss low across reset release does not produce a false start.
    armed_d         = armed_q | ((init_q == 2'd3) & ss_sync_q[1]);

    case (state_q)
      IDLE: begin
        if (ss_fall && armed_q) begin
          state_d       = ACTIVE;
          frame_start_d = 1'b1;
          bit_cnt_d     = 3'd0;
          byte_index_d  = 8'h00;
          byte_done_d   = 1'b0;
          tx_shift_d    = byte_send;
        end
      end
      ACTIVE: begin
        // ss deassertion wins over any sclk edge seen in the same cycle.
        if (ss_rise) begin
          state_d     = IDLE;
          frame_end_d = 1'b1;
          bit_cnt_d   = 3'd0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_bit};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_data_d     = {rx_shift_q[6:0], mosi_bit};
            byte_received_d = 1'b1;
            byte_index_d    = byte_index_q + 8'd1;
            byte_done_d     = 1'b1;
          end
        end else if (sclk_fall) begin
          // The fall after the last bit of a byte presents the next byte.
          if (bit_cnt_q == 3'd0 && byte_done_q) begin
            tx_shift_d = byte_send;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign miso               = (state_q == ACTIVE) ? tx_shift_q[7] : 1'bz;
  assign byte_received      = byte_received_q;
  assign byte_data_received = byte_data_q;
  assign frame_start        = frame_start_q;
  assign frame_end          = frame_end_q;
  assign byte_index         = byte_index_q;

endmodule

// File: tb/tb_spi_byte_port.sv
// tb/tb_spi_byte_port.sv - self-checking bench for spi_byte_port
`timescale 1ns/1ps
module tb_spi_byte_port;

  logic       clock_50;
  logic       reset;
  logic       sclk;
  logic       mosi;
  logic       ss;
  wire        miso;
  logic [7:0] byte_send;
  logic       byte_received;
  logic [7:0] byte_data_received;
  logic       frame_start;
  logic       frame_end;
  logic [7:0] byte_index;

  spi_byte_port dut (
    .clock_50           (clock_50),
    .reset              (reset),
    .sclk               (sclk),
    .mosi               (mosi),
    .ss                 (ss),
    .miso               (miso),
    .byte_send          (byte_send),
    .byte_received      (byte_received),
    .byte_data_received (byte_data_received),
    .frame_start        (frame_start),
    .frame_end          (frame_end),
    .byte_index         (byte_index)
  );

  initial clock_50 = 1'b0;
  always #10 clock_50 = ~clock_50;

  int n_cmp;
  int n_bad;
  int cyc;
  int br_cnt;
  int fs_cnt;
  int fe_cnt;
  int rise_cyc;
  int last_lat;

  initial begin
    cyc = 0; br_cnt = 0; fs_cnt = 0; fe_cnt = 0; last_lat = 0;
  end

  always @(posedge clock_50) cyc++;

  always @(negedge clock_50) begin
    if (byte_received) begin
      br_cnt++;
      last_lat = cyc - rise_cyc;
    end
    if (frame_start) fs_cnt++;
    if (frame_end) fe_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Host side of nbits SPI mode-0 bits, MSB first; sclk half period 5 cycles.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit do_mid,
                          input logic [7:0] mid, output logic [7:0] mbits);
    mbits = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      repeat (5) @(negedge clock_50);
      mbits[i] = miso;
      rise_cyc = cyc;
      sclk = 1'b1;
      repeat (5) @(negedge clock_50);
      sclk = 1'b0;
      if (do_mid && i == 4) byte_send = mid;
    end
  endtask

  task automatic end_frame();
    repeat (5) @(negedge clock_50);
    ss = 1'b1;
    repeat (8) @(negedge clock_50);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] send;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    logic [7:0] exp_idx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] mb, m0, m1, m2;
    int b0, f0, e0, bad_rx;

    n_cmp = 0; n_bad = 0;
    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'd1};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'd1};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'd1};
    vecs[3] = '{8'h5A, 8'h81, 8'h5A, 8'h81, 8'd1};
    vecs[4] = '{8'h80, 8'h01, 8'h80, 8'h01, 8'd1};

    reset = 1'b0; sclk = 1'b0; mosi = 1'b0; ss = 1'b1; byte_send = 8'h00;
    rise_cyc = 0;
    repeat (3) @(negedge clock_50);
    check("rst_index", byte_index, 8'h00);
    check("rst_data", byte_data_received, 8'h00);
    check("rst_pulses", {byte_received, frame_start, frame_end}, 3'b000);
    check("rst_miso_z", (miso === 1'bz), 1'b1);
    reset = 1'b1;
    repeat (10) @(negedge clock_50);

    // Idle noise: sclk toggles with ss high.
    for (int t = 0; t < 20; t++) begin
      sclk = ~sclk;
      repeat (3) @(negedge clock_50);
    end
    sclk = 1'b0;
    repeat (5) @(negedge clock_50);
    check("idle_br", br_cnt, 0);
    check("idle_fs", fs_cnt, 0);
    check("idle_fe", fe_cnt, 0);
    check("idle_miso_z", (miso === 1'bz), 1'b1);

    // Single-byte frames from the vector table.
    for (int v = 0; v < 5; v++) begin
      b0 = br_cnt; f0 = fs_cnt; e0 = fe_cnt;
      byte_send = vecs[v].send;
      ss = 1'b0;
      spi_bits(vecs[v].tx, 8, 1'b0, 8'h00, mb);
      check("vec_rx", byte_data_received, vecs[v].exp_rx);
      check("vec_miso", mb, vecs[v].exp_miso);
      check("vec_index", byte_index, vecs[v].exp_idx);
      check("vec_br", br_cnt - b0, 1);
      check("vec_latency_ok", (last_lat >= 3 && last_lat <= 4), 1'b1);
      end_frame();
      check("vec_fs", fs_cnt - f0, 1);
      check("vec_fe", fe_cnt - e0, 1);
      check("vec_miso_z", (miso === 1'bz), 1'b1);
    end

    // Back-to-back bytes; byte_send changes between and inside bytes.
    b0 = br_cnt;
    byte_send = 8'h3C;
    ss = 1'b0;
    spi_bits(8'h01, 8, 1'b0, 8'h00, m0);
    check("b2b_rx0", byte_data_received, 8'h01);
    byte_send = 8'h55;
    spi_bits(8'h02, 8, 1'b1, 8'hFF, m1);
    check("b2b_rx1", byte_data_received, 8'h02);
    spi_bits(8'h03, 8, 1'b0, 8'h00, m2);
    check("b2b_rx2", byte_data_received, 8'h03);
    check("b2b_tx0", m0, 8'h3C);
    check("b2b_tx1", m1, 8'h55);
    check("b2b_tx2", m2, 8'hFF);
    check("b2b_index", byte_index, 8'd3);
    check("b2b_br", br_cnt - b0, 3);
    end_frame();

    // Partial byte discarded, then a good frame.
    b0 = br_cnt; e0 = fe_cnt;
    ss = 1'b0;
    spi_bits(8'hC8, 5, 1'b0, 8'h00, mb);
    end_frame();
    check("part_br", br_cnt - b0, 0);
    check("part_fe", fe_cnt - e0, 1);
    check("part_data", byte_data_received, 8'h03);
    check("part_index", byte_index, 8'd0);
    ss = 1'b0;
    spi_bits(8'hFF, 8, 1'b0, 8'h00, mb);
    check("part_next_rx", byte_data_received, 8'hFF);
    check("part_next_index", byte_index, 8'd1);
    end_frame();

    // ss rise in the same cycle as the 8th sclk rise: no byte completes.
    b0 = br_cnt; e0 = fe_cnt;
    ss = 1'b0;
    spi_bits(8'h00, 7, 1'b0, 8'h00, mb);
    mosi = 1'b1;
    repeat (5) @(negedge clock_50);
    sclk = 1'b1;
    ss = 1'b1;
    repeat (10) @(negedge clock_50);
    sclk = 1'b0;
    repeat (8) @(negedge clock_50);
    check("tie_br", br_cnt - b0, 0);
    check("tie_fe", fe_cnt - e0, 1);
    check("tie_data", byte_data_received, 8'hFF);

    // Reset mid-byte, release with ss still low.
    byte_send = 8'h3C;
    ss = 1'b0;
    spi_bits(8'hF0, 4, 1'b0, 8'h00, mb);
    reset = 1'b0;
    #1;
    check("mrst_index", byte_index, 8'h00);
    check("mrst_data", byte_data_received, 8'h00);
    check("mrst_pulses", {byte_received, frame_start, frame_end}, 3'b000);
    check("mrst_miso_z", (miso === 1'bz), 1'b1);
    repeat (3) @(negedge clock_50);
    f0 = fs_cnt; e0 = fe_cnt; b0 = br_cnt;
    reset = 1'b1;
    repeat (10) @(negedge clock_50);
    check("mrst_no_fs", fs_cnt - f0, 0);
    ss = 1'b1;
    repeat (10) @(negedge clock_50);
    check("mrst_no_fe", fe_cnt - e0, 0);
    ss = 1'b0;
    spi_bits(8'h80, 8, 1'b0, 8'h00, mb);
    check("mrst_rx", byte_data_received, 8'h80);
    check("mrst_fs", fs_cnt - f0, 1);
    check("mrst_br", br_cnt - b0, 1);
    check("mrst_index1", byte_index, 8'd1);
    end_frame();

    // 256 bytes in one frame: byte_index wraps to 0.
    b0 = br_cnt;
    bad_rx = 0;
    ss = 1'b0;
    for (int k = 0; k < 256; k++) begin
      spi_bits(k[7:0], 8, 1'b0, 8'h00, mb);
      if (byte_data_received !== k[7:0]) bad_rx++;
      if (k == 0) check("wrap_index1", byte_index, 8'd1);
      if (k == 254) check("wrap_index255", byte_index, 8'd255);
    end
    check("wrap_rx_errors", bad_rx, 0);
    check("wrap_index0", byte_index, 8'd0);
    check("wrap_br", br_cnt - b0, 256);
    end_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
